// File: rtl/nand_arb_pkg.sv
// rtl/nand_arb_pkg.sv - shared state encodings and default sizes for nand_arb
package nand_arb_pkg;

    localparam int WIDTH_DEF = 8;
    localparam int N_REQ_DEF = 4;
    localparam int IDW       = $clog2(N_REQ_DEF);

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        EXEC = 2'b01,
        DONE = 2'b10
    } state_t;

endpackage

// File: rtl/nand_arb_rr_pick.sv
// rtl/nand_arb_rr_pick.sv - winner selection; NAND_ARB_FIXED_PRI_EN gives lowest-index priority
module rr_pick #(
    parameter int N_REQ = 4,
    parameter int IW    = 2
) (
    input  logic [N_REQ-1:0] req,
`ifndef NAND_ARB_FIXED_PRI_EN
    input  logic [IW-1:0]    ptr,
`endif
    output logic             found,
    output logic [IW-1:0]    idx
);

`ifdef NAND_ARB_FIXED_PRI_EN
    always_comb begin
        found = |req;
        idx   = '0;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            if (req[k]) idx = IW'(k);
        end
    end
`else
    logic [IW-1:0] pos;

    // Walk offsets from the far end so the nearest set bit at/after ptr wins;
    // N_REQ is a power of two so the IW-bit add wraps for free.
    always_comb begin
        found = |req;
        idx   = '0;
        pos   = '0;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            pos = ptr + IW'(k);
            if (req[pos]) idx = pos;
        end
    end
`endif

endmodule

// File: rtl/nand_arb.sv
// rtl/nand_arb.sv - shared NAND datapath arbiter; NAND_ARB_FIXED_PRI_EN selects fixed priority
module nand_arb
    import nand_arb_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int N_REQ = N_REQ_DEF,
    localparam int IW   = $clog2(N_REQ)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [N_REQ-1:0]       req,
    input  logic [N_REQ*WIDTH-1:0] a_in,
    input  logic [N_REQ*WIDTH-1:0] b_in,
    output logic [N_REQ-1:0]       gnt,
    output logic                   busy,
    output logic [WIDTH-1:0]       y_out,
    output logic                   valid,
    output logic [IW-1:0]          id_out
);

    state_t            state_q, state_d;
    logic [WIDTH-1:0]  op_a, op_b;
    logic [IW-1:0]     win_id;
    logic              pick_found;
    logic [IW-1:0]     pick_idx;

`ifndef NAND_ARB_FIXED_PRI_EN
    logic [IW-1:0]     ptr;
`endif

    rr_pick #(.N_REQ(N_REQ), .IW(IW)) u_pick (
        .req   (req),
`ifndef NAND_ARB_FIXED_PRI_EN
        .ptr   (ptr),
`endif
        .found (pick_found),
        .idx   (pick_idx)
    );

    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (pick_found) state_d = EXEC;
            EXEC:    state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        busy = (state_q != IDLE);
    end

    // Operands are captured only on IDLE->EXEC so later input changes cannot leak in.
    always_ff @(posedge clk) begin
        if (rst) begin
            gnt    <= '0;
            valid  <= 1'b0;
            y_out  <= '0;
            id_out <= '0;
            op_a   <= '0;
            op_b   <= '0;
            win_id <= '0;
`ifndef NAND_ARB_FIXED_PRI_EN
            ptr    <= '0;
`endif
        end else begin
            case (state_q)
                IDLE: begin
                    if (pick_found) begin
                        op_a   <= a_in[int'(pick_idx)*WIDTH +: WIDTH];
                        op_b   <= b_in[int'(pick_idx)*WIDTH +: WIDTH];
                        gnt    <= N_REQ'(1) << pick_idx;
                        win_id <= pick_idx;
                    end
                end
                EXEC: begin
                    y_out  <= ~(op_a & op_b);
                    id_out <= win_id;
                    valid  <= 1'b1;
                end
                DONE: begin
                    gnt   <= '0;
                    valid <= 1'b0;
`ifndef NAND_ARB_FIXED_PRI_EN
                    ptr   <= win_id + IW'(1);
`endif
                end
                default: begin
                    gnt   <= '0;
                    valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_nand_arb.sv
// tb/tb_nand_arb.sv - self-checking bench for nand_arb (default round-robin build)
module tb_nand_arb;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  req;
    logic [31:0] a_in, b_in;
    logic [3:0]  gnt;
    logic        busy;
    logic [7:0]  y_out;
    logic        valid;
    logic [1:0]  id_out;

    int pass_cnt = 0;
    int total    = 0;

    typedef struct {
        logic [3:0]  req;
        logic [31:0] a;
        logic [31:0] b;
        logic [3:0]  gnt;
        logic [7:0]  y;
        logic [1:0]  id;
    } vec_t;

    vec_t vecs[7];

    nand_arb #(.WIDTH(8), .N_REQ(4)) dut (
        .clk    (clk),
        .rst    (rst),
        .req    (req),
        .a_in   (a_in),
        .b_in   (b_in),
        .gnt    (gnt),
        .busy   (busy),
        .y_out  (y_out),
        .valid  (valid),
        .id_out (id_out)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic run_vec(input int i, input vec_t v);
        req  = v.req;
        a_in = v.a;
        b_in = v.b;
        tick();
        chk($sformatf("v%0d gnt", i), 32'(gnt), 32'(v.gnt));
        chk($sformatf("v%0d busy", i), 32'(busy), 32'd1);
        tick();
        chk($sformatf("v%0d valid", i), 32'(valid), 32'd1);
        chk($sformatf("v%0d y", i), 32'(y_out), 32'(v.y));
        chk($sformatf("v%0d id", i), 32'(id_out), 32'(v.id));
        req = 4'b0000;
        tick();
        chk($sformatf("v%0d valid_drop", i), 32'(valid), 32'd0);
        chk($sformatf("v%0d gnt_clear", i), 32'(gnt), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int nv;
        int last;
        logic [1:0] exp_id;
        logic [7:0] exp_y;
        logic [7:0] a_lane;
        logic [31:0] a_s1;
        logic seen;

        // ptr walk: 0 ->1 ->2 ->(wrap) 0 ->1 ->3 ->2 ->0
        vecs[0] = '{4'b0001, 32'h5A5A5AF0, 32'hA5A5A53C, 4'b0001, 8'hCF, 2'd0};
        vecs[1] = '{4'b0010, 32'hEEEE00EE, 32'hDDDD00DD, 4'b0010, 8'hFF, 2'd1};
        vecs[2] = '{4'b0011, 32'h123499AA, 32'h5678FF55, 4'b0001, 8'hFF, 2'd0};
        vecs[3] = '{4'b1010, 32'h3C00AA11, 32'hFF00AA22, 4'b0010, 8'h55, 2'd1};
        vecs[4] = '{4'b1001, 32'h12000080, 32'h340000FF, 4'b1000, 8'hEF, 2'd3};
        vecs[5] = '{4'b1100, 32'h66C30000, 32'h770F0000, 4'b0100, 8'hFC, 2'd2};
        vecs[6] = '{4'b0001, 32'h000000FF, 32'h000000FF, 4'b0001, 8'h00, 2'd0};

        rst = 1'b1; req = '0; a_in = '0; b_in = '0;
        repeat (3) tick();
        chk("rst gnt", 32'(gnt), 32'd0);
        chk("rst busy", 32'(busy), 32'd0);
        chk("rst valid", 32'(valid), 32'd0);
        chk("rst y", 32'(y_out), 32'd0);
        chk("rst id", 32'(id_out), 32'd0);
        rst = 1'b0;
        tick();

        for (int i = 0; i < 7; i++) run_vec(i, vecs[i]);

        // All requesters held: reset puts ptr back to 0, order must be 0,1,2,3,0.
        rst = 1'b1;
        tick();
        rst = 1'b0;
        a_s1 = 32'h08040201;
        a_in = a_s1;
        b_in = 32'hFFFFFFFF;
        req  = 4'b1111;
        nv = 0;
        last = 0;
        for (int c = 1; c <= 40; c++) begin
            tick();
            if (valid) begin
                exp_id = 2'(nv % 4);
                a_lane = a_s1[exp_id*8 +: 8];
                exp_y  = ~a_lane;
                chk($sformatf("rr%0d id", nv), 32'(id_out), 32'(exp_id));
                chk($sformatf("rr%0d y", nv), 32'(y_out), 32'(exp_y));
                chk($sformatf("rr%0d gnt", nv), 32'(gnt), 32'(4'b0001 << exp_id));
                if (nv > 0) chk($sformatf("rr%0d spacing", nv), 32'(c - last), 32'd3);
                last = c;
                nv++;
                if (nv == 5) break;
            end
        end
        chk("rr valid count", 32'(nv), 32'd5);
        req = 4'b0000;
        tick();
        tick();

        // ptr=1 now; operands and req change during EXEC must not matter.
        req  = 4'b0010;
        a_in = 32'h0000FF00;
        b_in = 32'h0000FF00;
        tick();
        chk("hold gnt", 32'(gnt), 32'b0010);
        a_in = 32'h0;
        b_in = 32'h0;
        req  = 4'b0000;
        tick();
        chk("hold valid", 32'(valid), 32'd1);
        chk("hold y", 32'(y_out), 32'h00);
        chk("hold id", 32'(id_out), 32'd1);
        tick();
        chk("hold idle", 32'(busy), 32'd0);

        // Reset while in EXEC discards the operation.
        req  = 4'b0001;
        a_in = 32'h000000F0;
        b_in = 32'h0000003C;
        tick();
        chk("rexec busy", 32'(busy), 32'd1);
        rst = 1'b1;
        req = 4'b0000;
        tick();
        chk("rexec gnt", 32'(gnt), 32'd0);
        chk("rexec busy0", 32'(busy), 32'd0);
        chk("rexec valid", 32'(valid), 32'd0);
        chk("rexec y", 32'(y_out), 32'd0);
        chk("rexec id", 32'(id_out), 32'd0);
        rst = 1'b0;
        seen = 1'b0;
        for (int c = 0; c < 3; c++) begin
            tick();
            if (valid) seen = 1'b1;
        end
        chk("rexec no pulse", 32'(seen), 32'd0);
        req  = 4'b0100;
        a_in = 32'h00AA0000;
        b_in = 32'h00550000;
        tick();
        chk("post gnt", 32'(gnt), 32'b0100);
        req = 4'b0000;
        tick();
        chk("post valid", 32'(valid), 32'd1);
        chk("post y", 32'(y_out), 32'hFF);
        chk("post id", 32'(id_out), 32'd2);
        tick();

        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end

endmodule
